// File: rtl/int_issue_queue.sv
// rtl/int_issue_queue.sv - integer issue queue: age-ordered buffer with CDB wakeup and oldest-ready issue
// Optional same-cycle empty-queue bypass enabled by defining ISSUEQ_INT_BYPASS_EN.
module int_issue_queue #(
    parameter int DEPTH  = 4,
    parameter int TAG_W  = 6,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en_int_dispatch,
    input  logic [6:0]        disp_opcode,
    input  logic [2:0]        disp_func3,
    input  logic [6:0]        disp_func7,
    input  logic [DATA_W-1:0] disp_rs1_data,
    input  logic [TAG_W-1:0]  disp_rs1_tag,
    input  logic              disp_rs1_rdy,
    input  logic [DATA_W-1:0] disp_rs2_data,
    input  logic [TAG_W-1:0]  disp_rs2_tag,
    input  logic              disp_rs2_rdy,
    input  logic [DATA_W-1:0] disp_imm,
    input  logic [TAG_W-1:0]  disp_rd_tag,
    input  logic [DATA_W-1:0] disp_br_addr,
    input  logic              cdb_valid,
    input  logic [TAG_W:0]    cdb_tag,
    input  logic [DATA_W-1:0] cdb_data,
    output logic              issueque_int_full,
    output logic              issue_valid,
    input  logic              issue_ready,
    output logic [6:0]        issue_opcode,
    output logic [2:0]        issue_func3,
    output logic [6:0]        issue_func7,
    output logic [DATA_W-1:0] issue_rs1_data,
    output logic [DATA_W-1:0] issue_rs2_data,
    output logic [DATA_W-1:0] issue_imm,
    output logic [TAG_W-1:0]  issue_rd_tag,
    output logic [DATA_W-1:0] issue_br_addr
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef struct packed {
        logic              valid;
        logic [6:0]        opcode;
        logic [2:0]        func3;
        logic [6:0]        func7;
        logic [DATA_W-1:0] rs1_data;
        logic [TAG_W-1:0]  rs1_tag;
        logic              rs1_rdy;
        logic [DATA_W-1:0] rs2_data;
        logic [TAG_W-1:0]  rs2_tag;
        logic              rs2_rdy;
        logic [DATA_W-1:0] imm;
        logic [TAG_W-1:0]  rd_tag;
        logic [DATA_W-1:0] br_addr;
    } entry_t;

    entry_t        ent_q [DEPTH];
    entry_t        ent_d [DEPTH];
    entry_t        ent_w [DEPTH];
    logic [CW-1:0] count_q, count_d;
    logic          full_q, full_d;

    logic [TAG_W-1:0] cdb_tag_lo;
    logic             unused_cdb_tag_msb;
    entry_t           disp_ent;
    entry_t           sel_ent;
    entry_t           out_ent;
    logic             sel_found;
    logic [IW-1:0]    sel_idx;
    logic             bypass_hit;
    logic             bypass_fire;
    logic             fire_arr;
    logic             wr_en;
    logic [CW-1:0]    wr_idx;

    assign cdb_tag_lo         = cdb_tag[TAG_W-1:0];
    assign unused_cdb_tag_msb = cdb_tag[TAG_W];

    // Incoming uop, with a source already satisfied by a broadcast in the same cycle
    always_comb begin
        disp_ent          = '0;
        disp_ent.valid    = 1'b1;
        disp_ent.opcode   = disp_opcode;
        disp_ent.func3    = disp_func3;
        disp_ent.func7    = disp_func7;
        disp_ent.rs1_tag  = disp_rs1_tag;
        disp_ent.rs1_rdy  = disp_rs1_rdy;
        disp_ent.rs1_data = disp_rs1_data;
        disp_ent.rs2_tag  = disp_rs2_tag;
        disp_ent.rs2_rdy  = disp_rs2_rdy;
        disp_ent.rs2_data = disp_rs2_data;
        disp_ent.imm      = disp_imm;
        disp_ent.rd_tag   = disp_rd_tag;
        disp_ent.br_addr  = disp_br_addr;
        if (cdb_valid && !disp_rs1_rdy && (disp_rs1_tag == cdb_tag_lo)) begin
            disp_ent.rs1_rdy  = 1'b1;
            disp_ent.rs1_data = cdb_data;
        end
        if (cdb_valid && !disp_rs2_rdy && (disp_rs2_tag == cdb_tag_lo)) begin
            disp_ent.rs2_rdy  = 1'b1;
            disp_ent.rs2_data = cdb_data;
        end
    end

    // Oldest-first select; scanning downward leaves the lowest ready index
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (ent_q[i].valid && ent_q[i].rs1_rdy && ent_q[i].rs2_rdy) begin
                sel_found = 1'b1;
                sel_idx   = IW'(i);
            end
        end
    end

    always_comb begin
        sel_ent = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (sel_found && (IW'(i) == sel_idx)) begin
                sel_ent = ent_q[i];
            end
        end
    end

`ifdef ISSUEQ_INT_BYPASS_EN
    assign bypass_hit = (count_q == '0) && en_int_dispatch && disp_rs1_rdy && disp_rs2_rdy;
`else
    assign bypass_hit = 1'b0;
`endif

    assign issue_valid = sel_found || bypass_hit;
    assign bypass_fire = bypass_hit && issue_ready;
    assign fire_arr    = sel_found && issue_ready && !bypass_hit;
    assign wr_en       = en_int_dispatch && !full_q && !bypass_fire;
    assign wr_idx      = count_q - CW'(fire_arr);

    always_comb begin
        out_ent = '0;
        if (bypass_hit) begin
            out_ent = disp_ent;
        end else if (sel_found) begin
            out_ent = sel_ent;
        end
    end

    assign issue_opcode   = out_ent.opcode;
    assign issue_func3    = out_ent.func3;
    assign issue_func7    = out_ent.func7;
    assign issue_rs1_data = out_ent.rs1_data;
    assign issue_rs2_data = out_ent.rs2_data;
    assign issue_imm      = out_ent.imm;
    assign issue_rd_tag   = out_ent.rd_tag;
    assign issue_br_addr  = out_ent.br_addr;

    // Wakeup applies to stored entries before compaction so a captured value shifts with its entry
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ent_w[i] = ent_q[i];
            if (cdb_valid && ent_q[i].valid) begin
                if (!ent_q[i].rs1_rdy && (ent_q[i].rs1_tag == cdb_tag_lo)) begin
                    ent_w[i].rs1_rdy  = 1'b1;
                    ent_w[i].rs1_data = cdb_data;
                end
                if (!ent_q[i].rs2_rdy && (ent_q[i].rs2_tag == cdb_tag_lo)) begin
                    ent_w[i].rs2_rdy  = 1'b1;
                    ent_w[i].rs2_data = cdb_data;
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ent_d[i] = ent_w[i];
        end
        if (fire_arr) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                if (IW'(i) >= sel_idx) begin
                    ent_d[i] = ent_w[i + 1];
                end
            end
            ent_d[DEPTH-1] = '0;
        end
        if (wr_en) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (CW'(i) == wr_idx) begin
                    ent_d[i] = disp_ent;
                end
            end
        end
        count_d = count_q - CW'(fire_arr) + CW'(wr_en);
        full_d  = (count_d == CW'(DEPTH));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= '0;
            end
            count_q <= '0;
            full_q  <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= ent_d[i];
            end
            count_q <= count_d;
            full_q  <= full_d;
        end
    end

    assign issueque_int_full = full_q;

endmodule

// File: tb/tb_int_issue_queue.sv
// tb/tb_int_issue_queue.sv - directed self-checking bench for int_issue_queue
module tb_int_issue_queue;

    logic        clk;
    logic        rst_n;
    logic        en_int_dispatch;
    logic [6:0]  disp_opcode;
    logic [2:0]  disp_func3;
    logic [6:0]  disp_func7;
    logic [31:0] disp_rs1_data;
    logic [5:0]  disp_rs1_tag;
    logic        disp_rs1_rdy;
    logic [31:0] disp_rs2_data;
    logic [5:0]  disp_rs2_tag;
    logic        disp_rs2_rdy;
    logic [31:0] disp_imm;
    logic [5:0]  disp_rd_tag;
    logic [31:0] disp_br_addr;
    logic        cdb_valid;
    logic [6:0]  cdb_tag;
    logic [31:0] cdb_data;
    logic        issueque_int_full;
    logic        issue_valid;
    logic        issue_ready;
    logic [6:0]  issue_opcode;
    logic [2:0]  issue_func3;
    logic [6:0]  issue_func7;
    logic [31:0] issue_rs1_data;
    logic [31:0] issue_rs2_data;
    logic [31:0] issue_imm;
    logic [5:0]  issue_rd_tag;
    logic [31:0] issue_br_addr;

    int checks = 0;
    int errors = 0;

    int_issue_queue #(.DEPTH(4), .TAG_W(6), .DATA_W(32)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .en_int_dispatch   (en_int_dispatch),
        .disp_opcode       (disp_opcode),
        .disp_func3        (disp_func3),
        .disp_func7        (disp_func7),
        .disp_rs1_data     (disp_rs1_data),
        .disp_rs1_tag      (disp_rs1_tag),
        .disp_rs1_rdy      (disp_rs1_rdy),
        .disp_rs2_data     (disp_rs2_data),
        .disp_rs2_tag      (disp_rs2_tag),
        .disp_rs2_rdy      (disp_rs2_rdy),
        .disp_imm          (disp_imm),
        .disp_rd_tag       (disp_rd_tag),
        .disp_br_addr      (disp_br_addr),
        .cdb_valid         (cdb_valid),
        .cdb_tag           (cdb_tag),
        .cdb_data          (cdb_data),
        .issueque_int_full (issueque_int_full),
        .issue_valid       (issue_valid),
        .issue_ready       (issue_ready),
        .issue_opcode      (issue_opcode),
        .issue_func3       (issue_func3),
        .issue_func7       (issue_func7),
        .issue_rs1_data    (issue_rs1_data),
        .issue_rs2_data    (issue_rs2_data),
        .issue_imm         (issue_imm),
        .issue_rd_tag      (issue_rd_tag),
        .issue_br_addr     (issue_br_addr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_disp(input logic [5:0] rd,
                            input logic r1, input logic [5:0] t1, input logic [31:0] d1,
                            input logic r2, input logic [5:0] t2, input logic [31:0] d2);
        en_int_dispatch = 1'b1;
        disp_opcode     = 7'h33;
        disp_func3      = 3'd0;
        disp_func7      = 7'd0;
        disp_rd_tag     = rd;
        disp_rs1_rdy    = r1;
        disp_rs1_tag    = t1;
        disp_rs1_data   = d1;
        disp_rs2_rdy    = r2;
        disp_rs2_tag    = t2;
        disp_rs2_data   = d2;
        disp_imm        = {26'd0, rd} << 4;
        disp_br_addr    = 32'h1000 + {26'd0, rd};
    endtask

    task automatic dispatch(input logic [5:0] rd,
                            input logic r1, input logic [5:0] t1, input logic [31:0] d1,
                            input logic r2, input logic [5:0] t2, input logic [31:0] d2);
        set_disp(rd, r1, t1, d1, r2, t2, d2);
        tick();
        en_int_dispatch = 1'b0;
        #1;
    endtask

    task automatic dispatch_ready(input logic [5:0] rd);
        dispatch(rd, 1'b1, 6'd0, {18'd0, rd, 8'h00}, 1'b1, 6'd0, {22'd0, rd, 4'h1});
    endtask

    initial begin
        rst_n = 1'b0;
        en_int_dispatch = 1'b0;
        disp_opcode = '0; disp_func3 = '0; disp_func7 = '0;
        disp_rs1_data = '0; disp_rs1_tag = '0; disp_rs1_rdy = 1'b0;
        disp_rs2_data = '0; disp_rs2_tag = '0; disp_rs2_rdy = 1'b0;
        disp_imm = '0; disp_rd_tag = '0; disp_br_addr = '0;
        cdb_valid = 1'b0; cdb_tag = '0; cdb_data = '0;
        issue_ready = 1'b0;

        #1;
        check("rst_count", 64'(dut.count_q), 64'd0);
        check("rst_full", 64'(issueque_int_full), 64'd0);
        check("rst_valid", 64'(issue_valid), 64'd0);
        check("rst_rd_tag", 64'(issue_rd_tag), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Fill to full, drop a fifth, then drain in age order
        for (int k = 1; k <= 4; k++) begin
            dispatch_ready(6'(k));
            check("fill_full", 64'(issueque_int_full), (k == 4) ? 64'd1 : 64'd0);
        end
        check("fill_count", 64'(dut.count_q), 64'd4);
        check("fill_head_rd", 64'(issue_rd_tag), 64'd1);
        check("fill_head_rs1", 64'(issue_rs1_data), 64'h100);
        check("fill_head_rs2", 64'(issue_rs2_data), 64'h11);
        check("fill_head_op", 64'(issue_opcode), 64'h33);
        check("fill_head_imm", 64'(issue_imm), 64'h10);
        check("fill_head_br", 64'(issue_br_addr), 64'h1001);
        dispatch_ready(6'd7);
        check("drop_count", 64'(dut.count_q), 64'd4);
        check("drop_head_rd", 64'(issue_rd_tag), 64'd1);
        issue_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            check("drain_rd", 64'(issue_rd_tag), 64'(k));
            tick();
        end
        check("drain_valid", 64'(issue_valid), 64'd0);
        check("drain_count", 64'(dut.count_q), 64'd0);
        check("drain_full", 64'(issueque_int_full), 64'd0);
        issue_ready = 1'b0;

        // Asynchronous reset with entries held
        for (int k = 1; k <= 3; k++) dispatch_ready(6'(k));
        check("pre_rst_count", 64'(dut.count_q), 64'd3);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_count", 64'(dut.count_q), 64'd0);
        check("arst_full", 64'(issueque_int_full), 64'd0);
        check("arst_valid", 64'(issue_valid), 64'd0);
        check("arst_rs1", 64'(issue_rs1_data), 64'd0);
        #1;
        rst_n = 1'b1;
        #1;

        // Wakeup from CDB; tag MSB must be ignored
        dispatch(6'd5, 1'b0, 6'd9, 32'h0, 1'b1, 6'd0, 32'h7);
        check("wait_valid", 64'(issue_valid), 64'd0);
        cdb_valid = 1'b1; cdb_tag = {1'b1, 6'd9}; cdb_data = 32'hDEAD;
        #1;
        check("wake_no_comb", 64'(issue_valid), 64'd0);
        tick();
        cdb_valid = 1'b0;
        #1;
        check("wake_valid", 64'(issue_valid), 64'd1);
        check("wake_rs1", 64'(issue_rs1_data), 64'hDEAD);
        check("wake_rd", 64'(issue_rd_tag), 64'd5);
        issue_ready = 1'b1;
        tick();
        issue_ready = 1'b0;
        #1;
        check("wake_drain", 64'(dut.count_q), 64'd0);

        // Younger ready entry overtakes a waiting older one
        dispatch(6'd10, 1'b1, 6'd0, 32'hA, 1'b0, 6'd3, 32'h0);
        dispatch_ready(6'd11);
        check("ooo_rd", 64'(issue_rd_tag), 64'd11);
        issue_ready = 1'b1;
        tick();
        check("ooo_after_valid", 64'(issue_valid), 64'd0);
        check("ooo_after_count", 64'(dut.count_q), 64'd1);
        cdb_valid = 1'b1; cdb_tag = 7'd3; cdb_data = 32'h33;
        tick();
        cdb_valid = 1'b0;
        #1;
        check("ooo_wake_rd", 64'(issue_rd_tag), 64'd10);
        check("ooo_wake_rs2", 64'(issue_rs2_data), 64'h33);
        tick();
        issue_ready = 1'b0;
        #1;
        check("ooo_drain", 64'(dut.count_q), 64'd0);

        // Full with dispatch+fire drops; count 2 with dispatch+fire holds
        for (int k = 1; k <= 4; k++) dispatch_ready(6'(k));
        issue_ready = 1'b1;
        dispatch_ready(6'd8);
        check("fullfire_count", 64'(dut.count_q), 64'd3);
        check("fullfire_full", 64'(issueque_int_full), 64'd0);
        check("fullfire_rd", 64'(issue_rd_tag), 64'd2);
        tick();
        check("two_count", 64'(dut.count_q), 64'd2);
        dispatch_ready(6'd9);
        check("dispfire_count", 64'(dut.count_q), 64'd2);
        check("dispfire_rd", 64'(issue_rd_tag), 64'd4);
        tick();
        check("landed_rd", 64'(issue_rd_tag), 64'd9);
        tick();
        issue_ready = 1'b0;
        #1;
        check("df_drain", 64'(dut.count_q), 64'd0);

        // Dispatch-cycle CDB capture on both sources
        cdb_valid = 1'b1; cdb_tag = 7'd20; cdb_data = 32'h55;
        dispatch(6'd12, 1'b0, 6'd20, 32'h0, 1'b0, 6'd20, 32'h0);
        cdb_valid = 1'b0;
        #1;
        check("cap_valid", 64'(issue_valid), 64'd1);
        check("cap_rs1", 64'(issue_rs1_data), 64'h55);
        check("cap_rs2", 64'(issue_rs2_data), 64'h55);
        issue_ready = 1'b1;
        tick();
        #1;
        check("cap_drain", 64'(dut.count_q), 64'd0);

        // Empty queue, ready uop with issue_ready=1
        set_disp(6'd13, 1'b1, 6'd0, 32'h13, 1'b1, 6'd0, 32'h31);
        #1;
`ifdef ISSUEQ_INT_BYPASS_EN
        check("byp_valid", 64'(issue_valid), 64'd1);
        check("byp_rd", 64'(issue_rd_tag), 64'd13);
        tick();
        en_int_dispatch = 1'b0;
        #1;
        check("byp_count", 64'(dut.count_q), 64'd0);
`else
        check("nobyp_valid", 64'(issue_valid), 64'd0);
        tick();
        en_int_dispatch = 1'b0;
        #1;
        check("nobyp_count", 64'(dut.count_q), 64'd1);
        check("nobyp_rd", 64'(issue_rd_tag), 64'd13);
        tick();
        check("nobyp_drain", 64'(dut.count_q), 64'd0);
`endif
        issue_ready = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
